// File: rtl/button_event_decoder.sv
// button_event_decoder: turns a debounced button level into press/click/long/repeat/release pulses.
module button_event_decoder #(
    parameter int CNT_W         = 16,
    parameter int LONG_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       button_level,
    input  logic       repeat_en,
    output logic       press_pulse,
    output logic       click_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       release_pulse,
    output logic       held,
    output logic [1:0] state,
    output logic [7:0] repeat_count
);
    typedef enum logic [1:0] {ARM = 2'd0, IDLE = 2'd1, PRESSED = 2'd2, LONG = 2'd3} state_t;
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_MAX  = CNT_W'(REPEAT_CYCLES - 1);
    state_t           st;
    logic [CNT_W-1:0] cnt;
    assign state = st;
    assign held  = st[1];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st            <= ARM;
            cnt           <= '0;
            repeat_count  <= '0;
            press_pulse   <= 1'b0;
            click_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            click_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            release_pulse <= 1'b0;
            case (st)
                ARM: if (!button_level) st <= IDLE;
                IDLE: if (button_level) begin
                    st           <= PRESSED;
                    press_pulse  <= 1'b1;
                    cnt          <= '0;
                    repeat_count <= '0;
                end
                // a release sampled on a threshold edge wins over the threshold
                PRESSED: if (!button_level) begin
                    st            <= IDLE;
                    click_pulse   <= 1'b1;
                    release_pulse <= 1'b1;
                    cnt           <= '0;
                end else if (cnt == LONG_MAX) begin
                    st         <= LONG;
                    long_pulse <= 1'b1;
                    cnt        <= '0;
                end else cnt <= cnt + CNT_W'(1);
                LONG: if (!button_level) begin
                    st            <= IDLE;
                    release_pulse <= 1'b1;
                    cnt           <= '0;
                end else if (!repeat_en) cnt <= '0;
                else if (cnt == REP_MAX) begin
                    repeat_pulse <= 1'b1;
                    cnt          <= '0;
                    repeat_count <= repeat_count == 8'hFF ? repeat_count : repeat_count + 8'd1;
                end else cnt <= cnt + CNT_W'(1);
            endcase
        end
    end
endmodule
